// File: rtl/gps_pkg.sv
// Shared definitions for the GPS serial path: frame width, line rate and receiver FSM encoding.
package gps_pkg;

  localparam int unsigned GpsB          = 8;
  localparam int unsigned GpsClockHz    = 100_000_000;
  localparam int unsigned GpsBaud       = 9600;
  localparam int unsigned GpsOversample = 16;

  localparam int unsigned S_Size = 3;

  typedef enum logic [S_Size-1:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd3,
    StBreak = 3'd4
  } rx_state_e;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int unsigned baud_divisor(input int unsigned clock_hz,
                                               input int unsigned baud,
                                               input int unsigned oversample);
    int unsigned ticks_per_sec;
    ticks_per_sec = baud * oversample;
    return (clock_hz + ticks_per_sec / 2) / ticks_per_sec;
  endfunction

endpackage

// File: rtl/baud_tick_generator.sv
// Oversample tick source; held at phase zero while disabled so ticks align to the enabling edge.
module baud_tick_generator
  import gps_pkg::*;
#(
  parameter int unsigned ClockHz    = GpsClockHz,
  parameter int unsigned Baud       = GpsBaud,
  parameter int unsigned Oversample = GpsOversample
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned Divisor = baud_divisor(ClockHz, Baud, Oversample);
  localparam int unsigned CntW    = (Divisor > 1) ? $clog2(Divisor) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Divisor - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (enable && (cnt_q != LastCnt)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && (cnt_q == LastCnt);

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART deserialiser with 16x oversampled mid-bit sampling, false-start and framing-error detection.
module uart_byte_receiver
  import gps_pkg::*;
#(
  parameter int unsigned B          = GpsB,
  parameter int unsigned ClockHz    = GpsClockHz,
  parameter int unsigned Baud       = GpsBaud,
  parameter int unsigned Oversample = GpsOversample
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         rx,
  output logic         load,
  output logic [B-1:0] data,
  output logic         frame_error,
  output logic         busy
);

  localparam int unsigned SampleW = $clog2(Oversample);
  localparam int unsigned BitW    = $clog2(B + 1);
  localparam logic [SampleW-1:0] MidSample  = SampleW'(Oversample / 2 - 1);
  localparam logic [SampleW-1:0] LastSample = SampleW'(Oversample - 1);
  localparam logic [BitW-1:0]    LastBit    = BitW'(B);

  logic sync1_q, rx_s_q, rx_prev_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  rx_state_e          state_q;
  logic [SampleW-1:0] sample_cnt_q;
  logic [BitW-1:0]    bit_cnt_q;
  logic [B-1:0]       shift_q;
  logic [B-1:0]       data_q;
  logic               load_q, frame_error_q;
  logic               tick, mid_bit, bit_end;

  assign busy = (state_q != StIdle);

  baud_tick_generator #(
    .ClockHz   (ClockHz),
    .Baud      (Baud),
    .Oversample(Oversample)
  ) u_baud_tick_generator (
    .clock (clock),
    .reset (reset),
    .enable(busy),
    .tick  (tick)
  );

  assign mid_bit = tick && (sample_cnt_q == MidSample);
  assign bit_end = tick && (sample_cnt_q == LastSample);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      sample_cnt_q  <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      load_q        <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      load_q        <= 1'b0;
      frame_error_q <= 1'b0;
      if (tick) begin
        sample_cnt_q <= bit_end ? '0 : sample_cnt_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (rx_prev_q && !rx_s_q) begin
            state_q      <= StStart;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
          end
        end
        StStart: begin
          if (mid_bit && rx_s_q) begin
            state_q <= StIdle;
          end else if (bit_end) begin
            state_q <= StData;
          end
        end
        StData: begin
          // Line is LSB first: each new bit enters at the MSB and walks down.
          if (mid_bit) begin
            shift_q   <= B'({rx_s_q, shift_q} >> 1);
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
          if (bit_end && (bit_cnt_q == LastBit)) begin
            state_q <= StStop;
          end
        end
        StStop: begin
          // Leave at mid-stop so a start bit with no idle gap is still caught.
          if (mid_bit) begin
            if (rx_s_q) begin
              data_q  <= shift_q;
              load_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              frame_error_q <= 1'b1;
              state_q       <= StBreak;
            end
          end
        end
        StBreak: begin
          if (rx_s_q) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign load        = load_q;
  assign data        = data_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Randomised and directed frames against an event-queue model of the receiver's externally visible behaviour.
module tb_uart_byte_receiver;

  localparam int unsigned B       = 8;
  localparam int unsigned BitClk  = 160;
  // Good-stop load (or frame error) lands (B+1.5) bit times plus 3 cycles after the start edge.
  localparam int unsigned Latency = (2 * B + 3) * BitClk / 2 + 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         rx  = 1'b1;
  logic         load, frame_error, busy;
  logic [B-1:0] data;

  always #5 clk = ~clk;

  uart_byte_receiver #(
    .B         (B),
    .ClockHz   (1_536_000),
    .Baud      (9600),
    .Oversample(16)
  ) dut (
    .clock      (clk),
    .reset      (rst),
    .rx         (rx),
    .load       (load),
    .data       (data),
    .frame_error(frame_error),
    .busy       (busy)
  );

  typedef struct {
    int           cyc;
    logic         err;
    logic [B-1:0] data;
  } evt_t;

  evt_t         exp_q[$];
  evt_t         ev;
  logic [B-1:0] model_data = '0;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_pass = 0;
  logic         mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) model_data = '0;
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check_eq("missed_event_cycle", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (load || frame_error) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_event", {30'd0, load, frame_error}, 32'd0);
        end else begin
          ev = exp_q.pop_front();
          check_eq("event_kind", {30'd0, load, frame_error}, ev.err ? 32'd1 : 32'd2);
          check_eq("event_cycle", cyc, ev.cyc);
          check_eq("busy_at_event", busy, ev.err);
          if (!ev.err) model_data = ev.data;
        end
      end
      check_eq("data_hold", data, model_data);
    end
  end

  // All stimulus tasks start and end just after a rising edge.
  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BitClk) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [B-1:0] b, input logic stop_ok, input int extra_low);
    exp_q.push_back('{cyc + Latency, !stop_ok, b});
    drive_bit(1'b0);
    for (int i = 0; i < B; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    if (!stop_ok) begin
      for (int i = 0; i < extra_low; i++) drive_bit(1'b0);
    end
  endtask

  initial begin
    logic [B-1:0] rb;
    logic         bad;
    string        sentence;

    #1 rst = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_load", load, 0);
    check_eq("rst_frame_error", frame_error, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_data", data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(20);

    send_frame(8'h24, 1'b1, 0);
    idle(200);
    check_eq("dollar_data", data, 8'h24);

    send_frame(8'h24, 1'b1, 0);
    send_frame(8'h47, 1'b1, 0);
    idle(200);
    check_eq("b2b_data", data, 8'h47);

    rx = 1'b0;
    repeat (20) @(posedge clk); #1;
    check_eq("glitch_busy_high", busy, 1);
    repeat (30) @(posedge clk); #1;
    rx = 1'b1;
    repeat (80) @(posedge clk); #1;
    check_eq("glitch_busy_low", busy, 0);
    idle(100);

    send_frame(8'h55, 1'b0, 3);
    check_eq("break_busy_high", busy, 1);
    check_eq("break_data_kept", data, 8'h47);
    idle(6);
    check_eq("break_busy_low", busy, 0);
    idle(200);

    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h41 >> i));
    rx = 1'b0;
    repeat (80) @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("async_rst_busy", busy, 0);
    @(negedge clk);
    check_eq("midrst_load", load, 0);
    check_eq("midrst_frame_error", frame_error, 0);
    check_eq("midrst_data", data, 0);
    @(posedge clk); #1;
    rx = 1'b1;
    repeat (5) @(posedge clk); #1;
    rst = 1'b0;
    idle(300);
    send_frame(8'h41, 1'b1, 0);
    idle(200);
    check_eq("after_rst_data", data, 8'h41);

    for (int k = 0; k < 16; k++) begin
      rb  = B'($urandom_range(0, 255));
      bad = ($urandom_range(0, 5) == 0);
      send_frame(rb, !bad, bad ? int'($urandom_range(0, 3)) : 0);
      if (bad) idle(int'($urandom_range(1, 3)) * BitClk);
      else idle(int'($urandom_range(0, 2)) * BitClk + int'($urandom_range(0, 1)) * 37);
    end
    idle(200);

    sentence = "$GPZDA,";
    for (int i = 0; i < sentence.len(); i++) send_frame(sentence[i], 1'b1, 0);
    idle(2000);
    check_eq("e2e_last_byte", data, 8'h2c);
    check_eq("pending_events", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
